// File: rtl/snn_ff_pkg.sv
// Shared definitions for the FF-STDP synaptic path: op encodings, the
// read-modify-write controller state type and default geometry.
package snn_ff_pkg;

    localparam int W_WIDTH_DEF     = 8;
    localparam int LANES_DEF       = 4;
    localparam int TOTAL_DEPTH_DEF = 12544;

    localparam logic OP_READ   = 1'b0;
    localparam logic OP_UPDATE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } rmw_state_t;

endpackage

// File: rtl/sat_lane_add.sv
// Signed saturating adder for one weight lane. The sum is formed one bit
// wider than the operands so overflow can be detected from the top two bits.
module sat_lane_add #(
    parameter int W_WIDTH = 8
) (
    input  logic [W_WIDTH-1:0] a,
    input  logic [W_WIDTH-1:0] b,
    output logic [W_WIDTH-1:0] y
);

    localparam logic [W_WIDTH-1:0] MAX_W = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic [W_WIDTH-1:0] MIN_W = {1'b1, {(W_WIDTH-1){1'b0}}};

    logic [W_WIDTH:0] sum_ext;

    // Sign-extend, add, then clamp when the two top bits disagree (overflow).
    always_comb begin
        sum_ext = {a[W_WIDTH-1], a} + {b[W_WIDTH-1], b};
        if (sum_ext[W_WIDTH] != sum_ext[W_WIDTH-1])
            y = sum_ext[W_WIDTH] ? MIN_W : MAX_W;
        else
            y = sum_ext[W_WIDTH-1:0];
    end

endmodule

// File: rtl/synaptic_rmw_ctrl.sv
// Initiator for the banked synaptic weight SRAM. Serves reads and
// read-modify-write weight updates (per-lane saturating add of signed
// deltas). All SRAM drive signals are registered and derived from the
// next state, so CS/WE line up exactly with the RD and WR states.
module synaptic_rmw_ctrl
    import snn_ff_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int W_WIDTH     = W_WIDTH_DEF,
    parameter int LANES       = LANES_DEF,
    parameter int TOTAL_DEPTH = TOTAL_DEPTH_DEF,
    parameter int AW          = $clog2(TOTAL_DEPTH)
) (
    input  logic                  CK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [AW-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0] req_delta,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [AW-1:0]         sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  err_addr,
    input  logic                  err_clr,
    output logic [15:0]           upd_cnt
);

    // One extra bit so a power-of-two depth still compares correctly.
    localparam logic [AW:0] DEPTH_LIM = TOTAL_DEPTH[AW:0];

    rmw_state_t state, state_nxt;

    logic                  op_q;
    logic [AW-1:0]         addr_q;
    logic [DATA_WIDTH-1:0] delta_q;
    logic [DATA_WIDTH-1:0] new_word;

    logic                  accept;
    logic                  addr_bad;
    logic                  cs_nxt;
    logic                  we_nxt;
    logic [AW-1:0]         a_nxt;
    logic [DATA_WIDTH-1:0] d_nxt;
    logic                  rsp_valid_nxt;

    assign accept   = req_valid & req_ready;
    assign addr_bad = ({1'b0, req_addr} >= DEPTH_LIM);

    // Per-lane saturating add of the stored word and the latched deltas.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sat_lane_add #(
            .W_WIDTH (W_WIDTH)
        ) u_lane (
            .a (sram_q [g*W_WIDTH +: W_WIDTH]),
            .b (delta_q[g*W_WIDTH +: W_WIDTH]),
            .y (new_word[g*W_WIDTH +: W_WIDTH])
        );
    end

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: fixed RD -> WT walk, then branch on the latched op.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && !addr_bad) state_nxt = ST_RD;
            ST_RD:   state_nxt = ST_WT;
            ST_WT:   state_nxt = (op_q == OP_UPDATE) ? ST_WR : ST_RSP;
            ST_WR:   state_nxt = ST_IDLE;
            ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: ready only in IDLE out of reset; SRAM drive values for the
    // next cycle are decoded from the next state and registered below.
    always_comb begin
        req_ready     = (state == ST_IDLE) && RST_N;
        cs_nxt        = (state_nxt == ST_RD) || (state_nxt == ST_WR);
        we_nxt        = (state_nxt == ST_WR);
        rsp_valid_nxt = (state_nxt == ST_RSP);
        a_nxt         = sram_a;
        d_nxt         = sram_d;
        if (state_nxt == ST_RD) a_nxt = req_addr;
        if (state_nxt == ST_WR) begin
            a_nxt = addr_q;
            d_nxt = new_word;
        end
    end

    // Latch the accepted request; out-of-range requests are dropped here.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            delta_q <= '0;
        end else if (accept && !addr_bad) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            delta_q <= req_delta;
        end
    end

    // Registered SRAM port drive.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            sram_cs <= 1'b0;
            sram_we <= 1'b0;
            sram_a  <= '0;
            sram_d  <= '0;
        end else begin
            sram_cs <= cs_nxt;
            sram_we <= we_nxt;
            sram_a  <= a_nxt;
            sram_d  <= d_nxt;
        end
    end

    // Read response: capture Q in WT and hold it through RSP backpressure.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rsp_valid_nxt;
            if (state == ST_WT && op_q == OP_READ) rsp_data <= sram_q;
        end
    end

    // Sticky address error; a clear wins over a same-cycle set.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N)                 err_addr <= 1'b0;
        else if (err_clr)           err_addr <= 1'b0;
        else if (accept && addr_bad) err_addr <= 1'b1;
    end

    // Completed-update counter, counts the write cycle and saturates.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N)
            upd_cnt <= '0;
        else if (state == ST_WR && upd_cnt != 16'hFFFF)
            upd_cnt <= upd_cnt + 16'd1;
    end

endmodule

// File: tb/tb_synaptic_rmw_ctrl.sv
// Bench for synaptic_rmw_ctrl: behavioural SRAM, read scoreboard, a table
// of update vectors (hand-computed plus random via a reference model) and
// directed sequences for the multi-cycle corner cases.
module tb_synaptic_rmw_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 12544;
    localparam int AW    = $clog2(DEPTH);

    logic          CK, RST_N;
    logic          req_valid, req_ready, req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_delta;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d, sram_q;
    logic          err_addr, err_clr;
    logic [15:0]   upd_cnt;

    synaptic_rmw_ctrl dut (
        .CK(CK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_delta(req_delta),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q),
        .err_addr(err_addr), .err_clr(err_clr), .upd_cnt(upd_cnt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] init;
        logic [DW-1:0] delta;
        logic [DW-1:0] expw;
    } vec_t;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] sb [$];
    vec_t          vq [$];

    int checks = 0, errors = 0;
    int cyc = 0, cs_cnt = 0, we_cnt = 0, we_cyc = 0, rsp_cnt = 0;
    int rsp_rise_cyc = 0, acc_cyc = 0, upd_exp = 0;
    logic rsp_prev = 1'b0;

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    initial forever begin
        @(posedge CK);
        cyc++;
    end

    // SRAM model: inputs sampled mid-cycle, effect applied just after the edge.
    initial begin
        logic          s_cs, s_we;
        logic [AW-1:0] s_a;
        logic [DW-1:0] s_d;
        sram_q = '0;
        forever begin
            @(negedge CK);
            s_cs = sram_cs; s_we = sram_we; s_a = sram_a; s_d = sram_d;
            @(posedge CK);
            #1;
            if (s_cs) begin
                if (s_we) mem[s_a] = s_d;
                else      sram_q = mem[s_a];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: port activity, WE/CS consistency and the read scoreboard.
    initial forever begin
        @(negedge CK);
        if (sram_cs) cs_cnt++;
        if (sram_we) begin
            we_cnt++;
            we_cyc = cyc;
        end
        check("we_implies_cs", {63'd0, sram_we & ~sram_cs}, 64'd0);
        if (rsp_valid && !rsp_prev) rsp_rise_cyc = cyc;
        rsp_prev = rsp_valid;
        if (rsp_valid) rsp_cnt++;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected actual=%h expected=none", rsp_data);
            end else begin
                check("rsp_data", {32'd0, rsp_data}, {32'd0, sb.pop_front()});
            end
        end
    end

    function automatic logic [DW-1:0] ref_upd(input logic [DW-1:0] w, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = int'($signed(w[8*i +: 8])) + int'($signed(d[8*i +: 8]));
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
            r[8*i +: 8] = s[7:0];
        end
        return r;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic op, input logic [AW-1:0] addr, input logic [DW-1:0] delta);
        int n;
        n = 0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_delta = delta;
        @(negedge CK);
        while (!req_ready && n < 50) begin
            @(negedge CK);
            n++;
        end
        if (!req_ready) begin
            errors++;
            $display("FAIL send_timeout actual=not_ready expected=ready");
        end
        acc_cyc = cyc;
        @(posedge CK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] expw);
        sb.push_back(expw);
        send(1'b0, addr, '0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CK);
            n++;
        end while (!(sb.size() == 0 && req_ready) && n < 40);
        if (n >= 40) begin
            errors++;
            $display("FAIL %s_idle_timeout actual=busy expected=idle", tag);
        end
        @(posedge CK);
        #1;
    endtask

    initial begin
        int b_cs, b_we, b_rsp, n;
        int acc[2];
        logic [DW-1:0] w, d;

        req_valid = 0; req_op = 0; req_addr = '0; req_delta = '0;
        rsp_ready = 1; err_clr = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset state
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CK);
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_sram", {30'd0, sram_cs, sram_we, sram_a, sram_d}, 64'd0);
        check("rst_rsp", {31'd0, rsp_valid, rsp_data}, 64'd0);
        check("rst_err_cnt", {47'd0, err_addr, upd_cnt}, 64'd0);
        RST_N = 1'b1;
        @(posedge CK);
        #1;

        // Read after preload: latency, single CS read cycle
        mem[5] = 32'h0A0B0C0D;
        b_cs = cs_cnt; b_we = we_cnt;
        do_read(14'd5, 32'h0A0B0C0D);
        wait_idle("read5");
        check("read_latency", 64'(rsp_rise_cyc - acc_cyc), 64'd3);
        check("read_cs_cycles", 64'(cs_cnt - b_cs), 64'd1);
        check("read_we_cycles", 64'(we_cnt - b_we), 64'd0);

        // Update vectors: hand-computed saturation cases, then random ones
        vq.push_back('{14'd7,     32'h7F801010, 32'h01FF05F0, 32'h7F801500});
        vq.push_back('{14'd8,     32'h7F800010, 32'h01FF05F0, 32'h7F800500});
        vq.push_back('{14'd20,    32'h00000000, 32'h80808080, 32'h80808080});
        vq.push_back('{14'd21,    32'h80808080, 32'h80808080, 32'h80808080});
        vq.push_back('{14'd22,    32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7F7F7F7F});
        vq.push_back('{14'd23,    32'h12345678, 32'h01020304, 32'h1336597C});
        vq.push_back('{14'd24,    32'hFF00FF00, 32'h01FF01FF, 32'h00FF00FF});
        vq.push_back('{14'd25,    32'hC040C040, 32'hC0C04040, 32'h8000007F});
        vq.push_back('{14'd12543, 32'h01010101, 32'h01010101, 32'h02020202});
        for (int i = 0; i < 6; i++) begin
            w = $urandom; d = $urandom;
            vq.push_back('{14'(100 + i), w, d, ref_upd(w, d)});
        end
        foreach (vq[i]) begin
            mem[vq[i].addr] = vq[i].init;
            b_cs = cs_cnt; b_we = we_cnt;
            send(1'b1, vq[i].addr, vq[i].delta);
            upd_exp++;
            wait_idle("upd");
            check($sformatf("upd_mem[%0d]", i), {32'd0, mem[vq[i].addr]}, {32'd0, vq[i].expw});
            check($sformatf("upd_cs[%0d]", i), 64'(cs_cnt - b_cs), 64'd2);
            check($sformatf("upd_we[%0d]", i), 64'(we_cnt - b_we), 64'd1);
            if (i == 0) begin
                check("upd_we_latency", 64'(we_cyc - acc_cyc), 64'd3);
                check("upd_cnt_first", {48'd0, upd_cnt}, 64'd1);
            end
            do_read(vq[i].addr, vq[i].expw);
            wait_idle("upd_rd");
        end
        check("upd_cnt_table", {48'd0, upd_cnt}, 64'(upd_exp));

        // Back-to-back updates to one address with valid held high
        mem[9] = '0;
        n = 0;
        req_valid = 1'b1; req_op = 1'b1; req_addr = 14'd9; req_delta = 32'h01010101;
        for (int k = 0; k < 30 && n < 2; k++) begin
            @(negedge CK);
            if (req_ready) begin
                acc[n] = cyc;
                n++;
            end
            @(posedge CK);
            #1;
        end
        req_valid = 1'b0;
        check("b2b_accepts", 64'(n), 64'd2);
        upd_exp += 2;
        wait_idle("b2b");
        if (n == 2) check("b2b_spacing", 64'(acc[1] - acc[0]), 64'd4);
        check("b2b_mem", {32'd0, mem[9]}, 64'h02020202);
        check("b2b_upd_cnt", {48'd0, upd_cnt}, 64'(upd_exp));

        // Out-of-range: dropped, sticky error, clear beats set
        b_cs = cs_cnt; b_rsp = rsp_cnt;
        send(1'b0, 14'd12544, '0);
        repeat (6) @(negedge CK);
        check("oor_err", {63'd0, err_addr}, 64'd1);
        check("oor_no_cs", 64'(cs_cnt - b_cs), 64'd0);
        check("oor_no_rsp", 64'(rsp_cnt - b_rsp), 64'd0);
        check("oor_idle", {63'd0, req_ready}, 64'd1);
        @(posedge CK);
        #1;
        req_valid = 1'b1; req_op = 1'b1; req_addr = 14'h3FFF; err_clr = 1'b1;
        @(negedge CK);
        check("oor_clr_accept", {63'd0, req_ready}, 64'd1);
        @(posedge CK);
        #1;
        req_valid = 1'b0; err_clr = 1'b0;
        @(negedge CK);
        check("oor_clr_wins", {63'd0, err_addr}, 64'd0);
        check("oor_clr_no_cs", 64'(cs_cnt - b_cs), 64'd0);
        @(posedge CK);
        #1;
        send(1'b1, 14'd13000, 32'h01010101);
        @(negedge CK);
        check("oor_reset_err", {63'd0, err_addr}, 64'd1);
        @(posedge CK);
        #1;
        err_clr = 1'b1;
        @(posedge CK);
        #1;
        err_clr = 1'b0;
        @(negedge CK);
        check("oor_clear", {63'd0, err_addr}, 64'd0);
        @(posedge CK);
        #1;

        // Response backpressure
        mem[30] = 32'hDEADBEEF;
        rsp_ready = 1'b0;
        do_read(14'd30, 32'hDEADBEEF);
        n = 0;
        @(negedge CK);
        while (!rsp_valid && n < 20) begin
            @(negedge CK);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_data", {32'd0, rsp_data}, 64'hDEADBEEF);
            check("bp_ready_low", {63'd0, req_ready}, 64'd0);
            @(negedge CK);
        end
        @(posedge CK);
        #1;
        rsp_ready = 1'b1;
        @(posedge CK);
        #1;
        @(negedge CK);
        check("bp_after_ready", {62'd0, req_ready, rsp_valid}, 64'd2);
        @(posedge CK);
        #1;

        // Reset during WT of an update
        mem[40] = 32'h11223344;
        send(1'b1, 14'd40, 32'h01010101);
        @(posedge CK);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_sram", {62'd0, sram_cs, sram_we}, 64'd0);
        check("mid_rst_cnt", {48'd0, upd_cnt}, 64'd0);
        check("mid_rst_ready", {63'd0, req_ready}, 64'd0);
        repeat (3) @(negedge CK);
        RST_N = 1'b1;
        @(posedge CK);
        #1;
        repeat (4) @(negedge CK);
        check("mid_rst_mem", {32'd0, mem[40]}, 64'h11223344);
        check("mid_rst_ready_after", {63'd0, req_ready}, 64'd1);
        check("mid_rst_cnt_after", {48'd0, upd_cnt}, 64'd0);
        @(posedge CK);
        #1;
        do_read(14'd40, 32'h11223344);
        wait_idle("post_rst");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
